elink_reset_seq: RTL and testbench
==================================

Name: elink_reset_seq

Overview:
- Parametrised multi-channel reset/PLL bring-up sequencer for elink clocking.
- Generalises the single-channel RX reset state machine to N independent channels, each driving one PLL (or MMCM) reset and one core nreset.
- Adds lock-timeout with bounded retry, loss-of-lock recovery, per-channel error latching and optional staggered bring-up.
- Sits beside the PLL primitives in the clock block; its outputs feed oh_rsync instances in each destination clock domain.

Parameters:
N, 2, number of channels
RCW, 8, heartbeat prescaler width; one heartbeat every 2^RCW cycles
HOLD, 4, heartbeats PLL reset is held in PLL_RST (>=1)
TMO, 16, heartbeats allowed in WAIT_LOCK before timeout (>=1)
RETRY, 3, timeouts tolerated before ERROR (>=1)
STAGGER, 1, 1: channel i leaves IDLE only while channel i-1 is ACTIVE; 0: channels independent

Ports:
clk  input  1  sys clock, free running
reset  input  1  synchronous, active-high reset
enable  input  N  per-channel enable, sync to clk; drives soft-reset-style control
pll_locked  input  N  PLL lock, asynchronous; synchronised internally
aux_ready  input  N  per-channel auxiliary ready (e.g. IDELAYCTRL RDY); tie 1 if unused; sync to clk
pll_reset  output  N  active-high PLL reset
active  output  N  channel in ACTIVE
nreset_out  output  N  active-low core reset; feed to oh_rsync
error  output  N  channel latched in ERROR
all_active  output  1  AND of active[N-1:0]

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high; all flops, including the prescaler, clear on `reset`. No async reset paths.
- Reset values: pll_reset all 1s, active 0, nreset_out 0, error 0, all_active 0. All FSMs are in IDLE, and all counters and sync flops are 0.
- Heartbeat: RCW-bit counter increments every cycle. hb is registered and equals 1 in the cycle after the counter holds all-ones. The first hb falls in cycle 2^RCW after reset deasserts (first cycle after reset = cycle 1). The counter wraps freely.
- Lock sync: 2-flop synchroniser per channel. lk[i] reflects pll_locked[i] 2 cycles later.
- Per-channel FSM states: IDLE, PLL_RST, WAIT_LOCK, ACTIVE, ERROR. Each channel has a step counter (width clog2(max(HOLD,TMO))+1) and a retry counter (clog2(RETRY)+1).
- Priority 1, any state: enable[i]=0 -> IDLE next cycle, whether or not hb is asserted. Step counter, retry counter and error[i] clear.
- Priority 2, ACTIVE with lk[i]=0 -> PLL_RST next cycle, whether or not hb is asserted. Retry counter clears; this is not an error.
- All other transitions occur only on hb:
  - IDLE -> PLL_RST when enable[i]=1 and (STAGGER=0 or i=0 or channel i-1 is in ACTIVE). Step counter is set to 0.
  - PLL_RST: step counter increments each hb. On the hb where it equals HOLD-1 -> WAIT_LOCK, step counter = 0.
  - WAIT_LOCK: if lk[i] and aux_ready[i] -> ACTIVE; retry counter clears.
  - WAIT_LOCK, else if step counter equals TMO-1: this is a timeout. The retry counter increments. If the new value equals RETRY -> ERROR; otherwise -> PLL_RST with step counter = 0.
  - WAIT_LOCK, otherwise: step counter increments.
  - ERROR: held until enable[i]=0.
- Staggered mode, upstream drop: if channel i-1 leaves ACTIVE, channels already past IDLE are not forced back. Only the IDLE exit is gated.
- Outputs:
  - pll_reset[i] = state in {IDLE, PLL_RST, ERROR}; decode of the state register, no extra latency.
  - active[i] = (state==ACTIVE).
  - error[i] = (state==ERROR).
  - nreset_out[i] registered: equals active[i] delayed 1 cycle, so it deasserts (goes 0) 1 cycle after leaving ACTIVE.
  - all_active is combinational from active.
- Simultaneous events:
  - enable drop coinciding with hb and lock: enable drop wins.
  - Lock arriving on the same hb as the timeout: lock wins (-> ACTIVE).
- Reset mid-operation: every state returns to reset values on the next edge, regardless of hb.

Test Plan:
- RCW=2, N=1, HOLD=2, TMO=4, enable=1, pll_locked=1 from start -> hbs at cycles 4, 8, 12, 16. IDLE->PLL_RST at 4, WAIT_LOCK at 12, ACTIVE at 16. nreset_out rises at 17; pll_reset falls at 12.
- Same setup, pll_locked=0 forever, RETRY=3 -> three timeouts, each followed by PLL_RST, then error=1 and pll_reset=1 held. Drop enable for 1 cycle -> error=0, state IDLE next cycle.
- ACTIVE channel, pll_locked pulses 0 for 3 cycles -> PLL_RST 3 cycles after the falling input; active and nreset_out drop within 1/2 cycles; re-lock follows HOLD+1 hbs later.
- N=2, STAGGER=1, both enabled, both locked -> ch1 stays IDLE until the first hb with ch0 ACTIVE. all_active=1 only once ch1 is ACTIVE. With STAGGER=0 -> both channels reach ACTIVE on the same hb.
- Lock rising on the same hb as the final timeout -> ACTIVE, error stays 0. aux_ready=0 with lock=1 -> timeout path is taken.
- reset asserted while ACTIVE -> next cycle: pll_reset=1, active=0, nreset_out=0, prescaler=0; first hb again 2^RCW cycles after reset release.

Source files
------------

// File: rtl/elink_reset_seq.sv
// Multi-channel PLL reset / bring-up sequencer for elink clocking.
// Heartbeat-paced per-channel FSMs with lock timeout, retry and stagger.
module elink_reset_seq #(
  parameter int N       = 2,
  parameter int RCW     = 8,
  parameter int HOLD    = 4,
  parameter int TMO     = 16,
  parameter int RETRY   = 3,
  parameter int STAGGER = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] enable,
  input  logic [N-1:0] pll_locked,
  input  logic [N-1:0] aux_ready,
  output logic [N-1:0] pll_reset,
  output logic [N-1:0] active,
  output logic [N-1:0] nreset_out,
  output logic [N-1:0] error,
  output logic         all_active
);

  localparam int SMAX = (HOLD > TMO) ? HOLD : TMO;
  localparam int SW   = $clog2(SMAX) + 1;
  localparam int RW   = $clog2(RETRY) + 1;

  localparam logic [SW-1:0] HOLD_L  = SW'(HOLD - 1);
  localparam logic [SW-1:0] TMO_L   = SW'(TMO - 1);
  localparam logic [RW-1:0] RETRY_L = RW'(RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLL_RST,
    S_WAIT_LOCK,
    S_ACTIVE,
    S_ERROR
  } state_e;

  logic [RCW-1:0] pre_q;
  logic           hb_q;
  logic [N-1:0]   sync_q;
  logic [N-1:0]   lk_q;
  logic [N-1:0]   nrst_q;
  logic [N-1:0]   act;
  logic [N-1:0]   up_ok;
  logic [N:0]     chain;

  state_e        st_q    [N];
  state_e        st_d    [N];
  logic [SW-1:0] step_q  [N];
  logic [SW-1:0] step_d  [N];
  logic [RW-1:0] retry_q [N];
  logic [RW-1:0] retry_d [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      hb_q   <= 1'b0;
      sync_q <= '0;
      lk_q   <= '0;
      nrst_q <= '0;
      for (int i = 0; i < N; i++) begin
        st_q[i]    <= S_IDLE;
        step_q[i]  <= '0;
        retry_q[i] <= '0;
      end
    end else begin
      pre_q  <= pre_q + 1'b1;
      hb_q   <= &pre_q;
      sync_q <= pll_locked;
      lk_q   <= sync_q;
      nrst_q <= act;
      for (int i = 0; i < N; i++) begin
        st_q[i]    <= st_d[i];
        step_q[i]  <= step_d[i];
        retry_q[i] <= retry_d[i];
      end
    end
  end

  always_comb begin
    act       = '0;
    pll_reset = '0;
    error     = '0;
    for (int i = 0; i < N; i++) begin
      act[i]       = (st_q[i] == S_ACTIVE);
      error[i]     = (st_q[i] == S_ERROR);
      pll_reset[i] = (st_q[i] == S_IDLE) ||
                     (st_q[i] == S_PLL_RST) ||
                     (st_q[i] == S_ERROR);
    end
  end

  // Channel i may leave IDLE only while its upstream neighbour is ACTIVE.
  assign chain = {act, 1'b1};
  assign up_ok = (STAGGER != 0) ? chain[N-1:0] : '1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      st_d[i]    = st_q[i];
      step_d[i]  = step_q[i];
      retry_d[i] = retry_q[i];
      if (!enable[i]) begin
        st_d[i]    = S_IDLE;
        step_d[i]  = '0;
        retry_d[i] = '0;
      end else if (st_q[i] == S_ACTIVE && !lk_q[i]) begin
        st_d[i]    = S_PLL_RST;
        step_d[i]  = '0;
        retry_d[i] = '0;
      end else if (hb_q) begin
        unique case (st_q[i])
          S_IDLE: begin
            if (up_ok[i]) begin
              st_d[i]   = S_PLL_RST;
              step_d[i] = '0;
            end
          end
          S_PLL_RST: begin
            if (step_q[i] == HOLD_L) begin
              st_d[i]   = S_WAIT_LOCK;
              step_d[i] = '0;
            end else begin
              step_d[i] = step_q[i] + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (lk_q[i] && aux_ready[i]) begin
              st_d[i]    = S_ACTIVE;
              retry_d[i] = '0;
            end else if (step_q[i] == TMO_L) begin
              retry_d[i] = retry_q[i] + 1'b1;
              step_d[i]  = '0;
              if (retry_d[i] == RETRY_L) begin
                st_d[i] = S_ERROR;
              end else begin
                st_d[i] = S_PLL_RST;
              end
            end else begin
              step_d[i] = step_q[i] + 1'b1;
            end
          end
          S_ACTIVE, S_ERROR: begin
          end
          default: st_d[i] = S_IDLE;
        endcase
      end
    end
  end

  assign active     = act;
  assign nreset_out = nrst_q;
  assign all_active = &act;

endmodule

// File: tb/tb_elink_reset_seq.sv
// Bench for elink_reset_seq: staggered and independent instances
// checked every cycle against a heartbeat-level channel model.
module tb_elink_reset_seq;

  localparam int PER   = 4;
  localparam int HOLD  = 2;
  localparam int TMO   = 4;
  localparam int RETRY = 3;

  localparam int M_OFF  = 0;
  localparam int M_HOLD = 1;
  localparam int M_WAIT = 2;
  localparam int M_UP   = 3;
  localparam int M_DEAD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] enable;
  logic [1:0] pll_locked;
  logic [1:0] aux_ready;

  logic [1:0] u0_pr, u0_act, u0_nr, u0_err;
  logic [1:0] u1_pr, u1_act, u1_nr, u1_err;
  logic       u0_all, u1_all;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  int   mst   [2][2];
  int   mleft [2][2];
  int   mwait [2][2];
  int   mtmo  [2][2];
  bit   mnres [2][2];
  bit [1:0] plh1, plh2;

  always #5 clk = ~clk;

  elink_reset_seq #(
    .N(2), .RCW(2), .HOLD(HOLD), .TMO(TMO),
    .RETRY(RETRY), .STAGGER(1)
  ) u0 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pll_locked (pll_locked),
    .aux_ready  (aux_ready),
    .pll_reset  (u0_pr),
    .active     (u0_act),
    .nreset_out (u0_nr),
    .error      (u0_err),
    .all_active (u0_all)
  );

  elink_reset_seq #(
    .N(2), .RCW(2), .HOLD(HOLD), .TMO(TMO),
    .RETRY(RETRY), .STAGGER(0)
  ) u1 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pll_locked (pll_locked),
    .aux_ready  (aux_ready),
    .pll_reset  (u1_pr),
    .active     (u1_act),
    .nreset_out (u1_nr),
    .error      (u1_err),
    .all_active (u1_all)
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, k);
    end
  endtask

  // Model: k is the cycle number since reset; heartbeats land on k%PER==0.
  task automatic model_edge();
    int  old [2][2];
    bit  hb;
    bit  lk, en, ax, up;
    if (reset) begin
      k = 0;
      plh1 = '0;
      plh2 = '0;
      for (int m = 0; m < 2; m++)
        for (int c = 0; c < 2; c++) begin
          mst[m][c]   = M_OFF;
          mleft[m][c] = 0;
          mwait[m][c] = 0;
          mtmo[m][c]  = 0;
          mnres[m][c] = 1'b0;
        end
      return;
    end
    hb  = (k > 0) && (k % PER == 0);
    old = mst;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) begin
        lk = plh2[c];
        en = enable[c];
        ax = aux_ready[c];
        up = 1'b1;
        if (m == 0 && c == 1) up = (old[0][0] == M_UP);
        mnres[m][c] = (old[m][c] == M_UP);
        if (!en) begin
          mst[m][c]  = M_OFF;
          mtmo[m][c] = 0;
        end else if (old[m][c] == M_UP && !lk) begin
          mst[m][c]   = M_HOLD;
          mleft[m][c] = HOLD;
          mtmo[m][c]  = 0;
        end else if (hb) begin
          case (old[m][c])
            M_OFF: if (up) begin
              mst[m][c]   = M_HOLD;
              mleft[m][c] = HOLD;
            end
            M_HOLD: begin
              mleft[m][c]--;
              if (mleft[m][c] == 0) begin
                mst[m][c]   = M_WAIT;
                mwait[m][c] = 0;
              end
            end
            M_WAIT: begin
              if (lk && ax) begin
                mst[m][c]  = M_UP;
                mtmo[m][c] = 0;
              end else begin
                mwait[m][c]++;
                if (mwait[m][c] == TMO) begin
                  mtmo[m][c]++;
                  if (mtmo[m][c] == RETRY) begin
                    mst[m][c] = M_DEAD;
                  end else begin
                    mst[m][c]   = M_HOLD;
                    mleft[m][c] = HOLD;
                  end
                end
              end
            end
            default: ;
          endcase
        end
      end
    k++;
    plh2 = plh1;
    plh1 = pll_locked;
  endtask

  task automatic compare();
    logic [1:0] epr, eact, enr, eerr;
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 2; c++) begin
        epr[c]  = (mst[m][c] == M_OFF) || (mst[m][c] == M_HOLD) ||
                  (mst[m][c] == M_DEAD);
        eact[c] = (mst[m][c] == M_UP);
        enr[c]  = mnres[m][c];
        eerr[c] = (mst[m][c] == M_DEAD);
      end
      chk($sformatf("u%0d_pll_reset", m), m == 0 ? u0_pr : u1_pr, epr);
      chk($sformatf("u%0d_active", m), m == 0 ? u0_act : u1_act, eact);
      chk($sformatf("u%0d_nreset", m), m == 0 ? u0_nr : u1_nr, enr);
      chk($sformatf("u%0d_error", m), m == 0 ? u0_err : u1_err, eerr);
      chk($sformatf("u%0d_all", m), m == 0 ? u0_all : u1_all, &eact);
    end
  endtask

  always @(posedge clk) begin
    #1;
    model_edge();
    compare();
  end

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (k != n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (k != n) begin
      total++;
      bad++;
      $display("FAIL wait_cyc: at cycle %0d want %0d", k, n);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 2'b00;
    pll_locked = 2'b00;
    aux_ready  = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_pr", u0_pr, 2'b11);
    chk("rst_act", u0_act, 2'b00);
    chk("rst_nr", u0_nr, 2'b00);
    chk("rst_err", u0_err, 2'b00);
    chk("rst_all", u0_all, 1'b0);
    reset      = 1'b0;
    enable     = 2'b01;
    pll_locked = 2'b11;

    // plain bring-up of channel 0
    wait_cyc(12); chk("up12_pr", u0_pr, 2'b11);
    wait_cyc(13); chk("up13_pr", u0_pr, 2'b10);
    wait_cyc(16); chk("up16_act", u0_act, 2'b00);
    wait_cyc(17); chk("up17_act", u0_act, 2'b01);
                  chk("up17_nr", u0_nr, 2'b00);
    wait_cyc(18); chk("up18_nr", u0_nr, 2'b01);

    // three-cycle lock glitch
    wait_cyc(20); pll_locked = 2'b10;
    wait_cyc(22); chk("lol22_act", u0_act, 2'b01);
    wait_cyc(23); chk("lol23_act", u0_act, 2'b00);
                  chk("lol23_nr", u0_nr, 2'b01);
                  pll_locked = 2'b11;
    wait_cyc(24); chk("lol24_nr", u0_nr, 2'b00);
    wait_cyc(32); chk("rel32_act", u0_act, 2'b00);
    wait_cyc(33); chk("rel33_act", u0_act, 2'b01);

    // lock lost for good: three timeouts then ERROR
    wait_cyc(36); pll_locked = 2'b10;
    wait_cyc(108); chk("tmo108_err", u0_err, 2'b00);
                   chk("tmo108_pr", u0_pr, 2'b10);
    wait_cyc(109); chk("tmo109_err", u0_err, 2'b01);
                   chk("tmo109_pr", u0_pr, 2'b11);
    wait_cyc(112); enable = 2'b00;
    wait_cyc(113); chk("clr113_err", u0_err, 2'b00);
                   chk("clr113_pr", u0_pr, 2'b11);
                   enable = 2'b01;

    // lock arrives exactly on the last timeout heartbeat
    wait_cyc(186); pll_locked = 2'b11;
    wait_cyc(188); chk("race188_act", u0_act, 2'b00);
    wait_cyc(189); chk("race189_act", u0_act, 2'b01);
                   chk("race189_err", u0_err, 2'b00);

    // locked but aux not ready: timeout path
    wait_cyc(192); enable = 2'b00;
    wait_cyc(193); enable = 2'b01; aux_ready = 2'b00;
    wait_cyc(220); chk("aux220_pr", u0_pr, 2'b10);
    wait_cyc(221); chk("aux221_pr", u0_pr, 2'b11);
                   chk("aux221_act", u0_act, 2'b00);
                   aux_ready = 2'b11;
    wait_cyc(229); chk("aux229_pr", u0_pr, 2'b10);
    wait_cyc(233); chk("aux233_act", u0_act, 2'b01);
                   chk("aux233_u1", u1_act, 2'b01);

    // reset while active, then both channels enabled
    wait_cyc(240); reset = 1'b1;
    @(negedge clk);
    chk("mid_k", k, 0);
    chk("mid_pr", {u1_pr, u0_pr}, 4'hf);
    chk("mid_act", {u1_act, u0_act}, 4'h0);
    chk("mid_nr", {u1_nr, u0_nr}, 4'h0);
    chk("mid_all", {u1_all, u0_all}, 2'b00);
    reset  = 1'b0;
    enable = 2'b11;
    wait_cyc(16); chk("stg16_u1all", u1_all, 1'b0);
    wait_cyc(17); chk("stg17_u1act", u1_act, 2'b11);
                  chk("stg17_u1all", u1_all, 1'b1);
                  chk("stg17_u0act", u0_act, 2'b01);
    wait_cyc(21); chk("stg21_u0pr", u0_pr, 2'b10);
    wait_cyc(32); chk("stg32_u0all", u0_all, 1'b0);
    wait_cyc(33); chk("stg33_u0all", u0_all, 1'b1);

    // upstream drop does not pull channel 1 back
    wait_cyc(36); pll_locked = 2'b10;
    wait_cyc(39); pll_locked = 2'b11;
    wait_cyc(40); chk("dn40_u0act", u0_act, 2'b10);
                  chk("dn40_u1act", u1_act, 2'b10);

    // enable drop on a heartbeat with lock present
    wait_cyc(48); enable = 2'b01;
    wait_cyc(49); chk("en49_u0act", u0_act, 2'b01);
                  chk("en49_u1act", u1_act, 2'b01);
                  chk("en49_u1pr", u1_pr, 2'b10);
    wait_cyc(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
